// File: rtl/cmp_seq_if.sv
//------------------------------------------------------------------------------
// cmp_seq_if : operand-in / flags-out handshake bundle for cmp_seq
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface cmp_seq_if #(
  parameter int NBYTES = 4
);
  logic                  in_valid;
  logic                  in_ready;
  logic [8*NBYTES-1:0]   a;
  logic [8*NBYTES-1:0]   b;
  logic                  out_valid;
  logic                  out_ready;
  logic                  fo_big;
  logic                  fo_equal;
  logic                  fo_small;
  logic                  busy;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, fo_big, fo_equal, fo_small, busy
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, fo_big, fo_equal, fo_small, busy
  );
endinterface

`default_nettype wire

// File: rtl/cmp_seq.sv
//------------------------------------------------------------------------------
// cmp_seq : byte-serial wide unsigned compare, MSB first, early exit
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module cmp8 (
  input  logic [7:0] a_i,
  input  logic [7:0] b_i,
  input  logic       gt_i,
  input  logic       eq_i,
  input  logic       lt_i,
  output logic       gt_o,
  output logic       eq_o,
  output logic       lt_o
);
  // Lower byte only matters while all higher bytes were equal.
  always_comb begin
    gt_o = gt_i | (eq_i & (a_i > b_i));
    eq_o = eq_i & (a_i == b_i);
    lt_o = lt_i | (eq_i & (a_i < b_i));
  end
endmodule

module cmp_seq #(
  parameter int NBYTES = 4
) (
  input  logic      sys_clk,
  input  logic      sys_rst_n,
  input  logic      clr,
  cmp_seq_if.slave  bus
);
  localparam int W    = 8 * NBYTES;
  localparam int IDXW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [W-1:0]      a_q, a_d;
  logic [W-1:0]      b_q, b_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic              run_gt_q, run_gt_d;
  logic              run_eq_q, run_eq_d;
  logic              run_lt_q, run_lt_d;
  logic              fo_big_q, fo_big_d;
  logic              fo_equal_q, fo_equal_d;
  logic              fo_small_q, fo_small_d;

  logic [W-1:0]      w_a_shift;
  logic [W-1:0]      w_b_shift;
  logic [7:0]        w_a_byte;
  logic [7:0]        w_b_byte;
  logic              w_gt;
  logic              w_eq;
  logic              w_lt;

  assign w_a_shift = a_q >> {idx_q, 3'b000};
  assign w_b_shift = b_q >> {idx_q, 3'b000};
  assign w_a_byte  = w_a_shift[7:0];
  assign w_b_byte  = w_b_shift[7:0];

  cmp8 u_cmp8 (
    .a_i  (w_a_byte),
    .b_i  (w_b_byte),
    .gt_i (run_gt_q),
    .eq_i (run_eq_q),
    .lt_i (run_lt_q),
    .gt_o (w_gt),
    .eq_o (w_eq),
    .lt_o (w_lt)
  );

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    idx_d      = idx_q;
    run_gt_d   = run_gt_q;
    run_eq_d   = run_eq_q;
    run_lt_d   = run_lt_q;
    fo_big_d   = fo_big_q;
    fo_equal_d = fo_equal_q;
    fo_small_d = fo_small_q;

    // Abort wins over accept and completion; published flags are untouched.
    if (clr) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            a_d      = bus.a;
            b_d      = bus.b;
            idx_d    = IDXW'(NBYTES - 1);
            run_gt_d = 1'b0;
            run_eq_d = 1'b1;
            run_lt_d = 1'b0;
            state_d  = CMP;
          end
        end
        CMP: begin
          run_gt_d = w_gt;
          run_eq_d = w_eq;
          run_lt_d = w_lt;
          if (w_eq && (idx_q != '0)) begin
            idx_d = idx_q - IDXW'(1);
          end else begin
            fo_big_d   = w_gt;
            fo_equal_d = w_eq;
            fo_small_d = w_lt;
            state_d    = DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q    <= IDLE;
      a_q        <= '0;
      b_q        <= '0;
      idx_q      <= '0;
      run_gt_q   <= 1'b0;
      run_eq_q   <= 1'b1;
      run_lt_q   <= 1'b0;
      fo_big_q   <= 1'b0;
      fo_equal_q <= 1'b0;
      fo_small_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      idx_q      <= idx_d;
      run_gt_q   <= run_gt_d;
      run_eq_q   <= run_eq_d;
      run_lt_q   <= run_lt_d;
      fo_big_q   <= fo_big_d;
      fo_equal_q <= fo_equal_d;
      fo_small_q <= fo_small_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE) && !clr;
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.fo_big    = fo_big_q;
  assign bus.fo_equal  = fo_equal_q;
  assign bus.fo_small  = fo_small_q;
endmodule

`default_nettype wire

// File: doc/cmp_seq.md
# cmp_seq

Byte-serial sequencer for wide unsigned magnitude compares. It time-shares one instance of the team's 8-bit cascade comparator, `cmp8`. Operands of `8*NBYTES` bits are accepted over a valid/ready handshake and compared one byte pair per cycle, most-significant byte first. The sequence terminates early on the first unequal byte pair, and a one-hot big/equal/small result is presented on a valid/ready output. The block sits between the operand source and the downstream consumer of compare flags. It replaces a chain of `NBYTES` comparators with one comparator plus control.

## Interface
- `NBYTES`, default 4: operand width in bytes; legal range 1..16.
- `sys_clk` in 1: clock; all state updates on the rising edge.
- `sys_rst_n` in 1: reset; asynchronous assert, active-low.
- `clr` in 1: synchronous abort; returns the block to IDLE.
- `in_valid` in 1: operand pair valid.
- `in_ready` out 1: block can accept an operand pair.
- `a` in `8*NBYTES`: operand A, unsigned.
- `b` in `8*NBYTES`: operand B, unsigned.
- `out_valid` out 1: result valid.
- `out_ready` in 1: consumer accepts the result.
- `fo_big` out 1: A > B.
- `fo_equal` out 1: A == B.
- `fo_small` out 1: A < B.
- `busy` out 1: high in CMP or DONE.

## Operation
- There is one clock and the reset is asynchronous, active-low (`sys_clk`, `sys_rst_n`).
- The FSM has three states: IDLE, CMP and DONE. Reset state is IDLE.
- `in_ready` = (state == IDLE) and not `clr`.
- `out_valid` = (state == DONE).
- `busy` = (state != IDLE).
- **Accept:**
  - Acceptance occurs when `in_valid && in_ready`.
  - On acceptance, `a` and `b` are registered into operand registers.
  - The byte index is set to `NBYTES-1`.
  - The running flags are set to big=0, equal=1, small=0, and the state moves to CMP.
- **CMP, each cycle:**
  - The comparator sees byte `idx` of each operand, with running flags as cascade inputs.
  - The comparator outputs are registered into the running flags.
  - If the comparator reports equal and `idx != 0`: decrement `idx` and stay in CMP.
  - Otherwise: copy the comparator outputs into `fo_*` and go to DONE.
- **DONE:**
  - Hold `out_valid`, `fo_*` and the operand registers stable.
  - On `out_ready`, go to IDLE.
- **Outputs:**
  - `fo_*` change only on the CMP→DONE transition.
  - They hold their value through IDLE until the next result is produced.
  - Exactly one of the three flags is high after the first result.
- **clr:**
  - In any state, the next state is IDLE.
  - The in-flight compare is discarded and `fo_*` are left unchanged.
  - `clr` has priority over acceptance and over completion in the same cycle.
- **Reset mid-operation:** all state returns immediately to reset values.
- **Unsigned arithmetic:** byte `i` is bits `[8i+7:8i]`, and no sign handling is applied.

## Timing
- Reset values:
  - state IDLE; `in_ready`=1.
  - `out_valid`=0, `busy`=0.
  - `fo_big`=0, `fo_equal`=0, `fo_small`=0.
  - `idx`=0, operand registers all 0.
- **Latency:**
  - Let k be the number of byte pairs examined: (index of the first differing byte from the MSB) + 1, or `NBYTES` if the operands are equal.
  - Acceptance edge is E0. `out_valid` rises after edge Ek.
  - Example for NBYTES=4: MSB difference gives `out_valid` one cycle after acceptance; equal operands give 4 cycles.
- **Handshake:**
  - Result transfer occurs when `out_valid && out_ready`.
  - `in_ready` is low from E0 until the cycle after the result transfer.
  - There is one mandatory IDLE cycle between transactions, so minimum throughput is one compare per k+2 cycles.
- `out_ready` may be held high continuously; DONE then lasts exactly one cycle.
- `in_valid` while not ready is ignored; `a` and `b` are not sampled.
- **NBYTES=1:** CMP lasts exactly one cycle, independent of the data.

## Test plan
- **Equal operands:** reset, then A=B=0x12345678 with NBYTES=4 and `out_ready`=1. Required: `out_valid` 4 cycles after acceptance, `fo_equal`=1, `busy` high for 5 cycles.
- **MSB early exit:** A=0x80000000, B=0x7FFFFFFF. Required: `out_valid` 1 cycle after acceptance, `fo_big`=1.
- **LSB difference:** A=0xAABBCC01, B=0xAABBCC02. Required: `out_valid` after 4 cycles, `fo_small`=1.
- **Back-pressure:** A=5, B=3, with `out_ready`=0 for 10 cycles. Required:
  - `out_valid` and `fo_big` are held throughout.
  - `in_ready` stays 0 and a new operand presented meanwhile is not accepted.
  - After `out_ready` is asserted, `in_ready`=1 in the following cycle.
- **Abort:** assert `clr` in the 2nd CMP cycle of A=B. Required:
  - State returns to IDLE next cycle and `out_valid` never asserts.
  - `fo_*` keep the previous result.
  - `clr` together with `in_valid` in IDLE causes no acceptance.
- **Async reset:** drop `sys_rst_n` mid-CMP without a clock edge. Required: all outputs go to their reset values immediately; after release, a normal compare of A=0, B=0xFFFFFFFF gives `fo_small`=1 after 1 cycle.
